// File: rtl/instr_pkg.sv
// Shared types and constants for the instr_enc register-protocol encoder.
// Frame byte0 = {rw, high, addr[5:0]}, byte1 = data.
package instr_pkg;

   localparam int RW_BIT   = 7;
   localparam int HIGH_BIT = 6;
   localparam int ADDR_MSB = 5;

   localparam int WR_BYTES = 2;
   localparam int RD_BYTES = 4;

   localparam logic [7:0] DUMMY_BYTE = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RX,
      DONE
   } state_t;

   typedef struct packed {
      logic       write;
      logic       high;
      logic [5:0] addr;
      logic [7:0] wdata;
   } req_t;

endpackage

// File: rtl/instr_enc_if.sv
// Request, byte-shifter and response signals of instr_enc.
// slave = encoder side, master = host/shifter side.
interface instr_enc_if;

   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic       req_high;
   logic [5:0] req_addr;
   logic [7:0] req_wdata;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       busy;

   modport slave (
      input  req_valid, req_write, req_high, req_addr, req_wdata,
      input  tx_ready, rx_valid, rx_data,
      output req_ready, tx_valid, tx_data,
      output rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport master (
      output req_valid, req_write, req_high, req_addr, req_wdata,
      output tx_ready, rx_valid, rx_data,
      input  req_ready, tx_valid, tx_data,
      input  rsp_valid, rsp_rdata, rsp_err, busy
   );

endinterface

// File: rtl/instr_enc_frame.sv
// Combinational protocol byte select for the latched request.
// Reads append a filler command frame so the slave stays aligned.
module instr_enc_frame
   import instr_pkg::*;
#(
   parameter logic [7:0] FILL_CMD = 8'h00
) (
   input  req_t       rq,
   input  logic [1:0] idx,
   output logic [7:0] frame_byte
);

   always_comb begin
      frame_byte = DUMMY_BYTE;
      unique case (1'b1)
         idx == 2'd0: begin
            frame_byte[RW_BIT]       = rq.write;
            frame_byte[HIGH_BIT]     = rq.high;
            frame_byte[ADDR_MSB:0]   = rq.addr;
         end
         idx == 2'd1: frame_byte = rq.write ? rq.wdata : DUMMY_BYTE;
         idx == 2'd2: frame_byte = FILL_CMD;
         default:     frame_byte = DUMMY_BYTE;
      endcase
   end

endmodule

// File: rtl/instr_enc.sv
// Host-side instruction encoder: serialises register requests into bytes.
// Define INSTR_ENC_TIMEOUT_EN for the per-byte handshake timeout/abort.
module instr_enc
   import instr_pkg::*;
#(
   parameter int         TIMEOUT_CYC = 1024,
   parameter logic [7:0] FILL_CMD    = 8'h00
) (
   input logic        clk,
   input logic        rst,
   instr_enc_if.slave bus
);

   state_t     state;
   req_t       rq;
   logic [1:0] idx;
   logic [7:0] rdata_q;
   logic [7:0] rdata_out;
   logic [7:0] byte_cur;
   logic       last;
   logic       tmo;

   instr_enc_frame #(
      .FILL_CMD(FILL_CMD)
   ) u_frame (
      .rq        (rq),
      .idx       (idx),
      .frame_byte(byte_cur)
   );

   assign last = idx == (rq.write ? 2'(WR_BYTES - 1) : 2'(RD_BYTES - 1));

   assign bus.req_ready = state == IDLE;
   assign bus.busy      = state != IDLE;
   assign bus.tx_valid  = state == SEND;
   assign bus.tx_data   = (state == SEND) ? byte_cur : 8'h00;
   assign bus.rsp_valid = state == DONE;
   assign bus.rsp_rdata = rdata_out;

`ifdef INSTR_ENC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;
   logic          err_q;
   logic          hs;

   assign hs  = (state == SEND && bus.tx_ready) ||
                (state == WAIT_RX && bus.rx_valid);
   assign tmo = (state == SEND || state == WAIT_RX) && !hs &&
                cnt == CW'(TIMEOUT_CYC - 1);

   // cnt clears on every state change into SEND/WAIT_RX
   always_ff @(posedge clk) begin
      if (rst || hs || state == IDLE || state == DONE)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
      if (rst || state == DONE)
         err_q <= 1'b0;
      else if (tmo)
         err_q <= 1'b1;
   end

   assign bus.rsp_err = (state == DONE) && err_q;
`else
   assign tmo         = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rq        <= '0;
         idx       <= '0;
         rdata_q   <= '0;
         rdata_out <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  rq      <= '{bus.req_write, bus.req_high,
                               bus.req_addr, bus.req_wdata};
                  idx     <= '0;
                  rdata_q <= '0;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (bus.tx_ready) begin
                  state <= WAIT_RX;
               end else if (tmo) begin
                  rdata_out <= '0;
                  state     <= DONE;
               end
            end
            WAIT_RX: begin
               if (bus.rx_valid) begin
                  // slave answers the B1 read strobe during frame B2
                  if (!rq.write && idx == 2'd2)
                     rdata_q <= bus.rx_data;
                  idx <= idx + 2'd1;
                  if (last) begin
                     rdata_out <= rq.write ? 8'h00 : rdata_q;
                     state     <= DONE;
                  end else begin
                     state <= SEND;
                  end
               end else if (tmo) begin
                  rdata_out <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               idx   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed and random register accesses
// against a frame-level reference model of the two-byte protocol.
module tb_instr_enc;
   import instr_pkg::*;

   localparam logic [7:0] FILL = 8'h00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   last_rsp_cyc = -100;

   instr_enc_if bus ();

   instr_enc #(
      .TIMEOUT_CYC(1024),
      .FILL_CMD   (FILL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input req_t op);
      bus.req_valid = 1'b1;
      bus.req_write = op.write;
      bus.req_high  = op.high;
      bus.req_addr  = op.addr;
      bus.req_wdata = op.wdata;
   endtask

   // reference: protocol frames and returned read data
   task automatic model(input req_t op, input logic [31:0] rxw,
                        output logic [7:0] eb [4], output int n,
                        output logic [7:0] rd);
      eb[0] = {op.write, op.high, op.addr};
      if (op.write) begin
         eb[1] = op.wdata; eb[2] = 8'h00; eb[3] = 8'h00;
         n = 2; rd = 8'h00;
      end else begin
         eb[1] = 8'h00; eb[2] = FILL; eb[3] = 8'h00;
         n = 4; rd = rxw[23:16];
      end
   endtask

   task automatic wait_tx(input string tag);
      int t = 0;
      while (bus.tx_valid !== 1'b1 && t < 100) begin
         @(negedge clk); t++;
      end
      chk(tag, bus.tx_valid, 1'b1);
   endtask

   task automatic accept_req(input bit hold, input req_t nxt,
                             input bit b2b);
      int t = 0;
      while (bus.req_ready !== 1'b1 && t < 100) begin
         @(negedge clk); t++;
      end
      chk("req_ready", bus.req_ready, 1'b1);
      if (b2b) chk("b2b_accept_gap", cyc - last_rsp_cyc, 1);
      @(negedge clk);
      if (hold) drive_req(nxt);
      else bus.req_valid = 1'b0;
      chk("busy_after_accept", bus.busy, 1'b1);
      chk("ready_after_accept", bus.req_ready, 1'b0);
   endtask

   task automatic send_byte(input int i, input logic [7:0] exp,
                            input logic [7:0] rx, input int stall);
      wait_tx($sformatf("tx_valid_b%0d", i));
      chk($sformatf("tx_b%0d", i), bus.tx_data, exp);
      for (int k = 0; k < stall; k++) begin
         bus.rx_valid = (k == 2);
         @(negedge clk);
         bus.rx_valid = 1'b0;
         chk("stall_valid", bus.tx_valid, 1'b1);
         chk("stall_data", bus.tx_data, exp);
      end
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
      chk($sformatf("tx_drop_b%0d", i), bus.tx_valid, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = rx;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic txn(input req_t op, input logic [31:0] rxw,
                      input int stall_idx, input int stall_n,
                      input bit hold, input req_t nxt, input bit b2b);
      logic [7:0] eb [4];
      logic [7:0] rd;
      int n;
      int t;
      model(op, rxw, eb, n, rd);
      if (!b2b) drive_req(op);
      accept_req(hold, nxt, b2b);
      for (int i = 0; i < n; i++)
         send_byte(i, eb[i], rxw[8*i +: 8],
                   (i == stall_idx) ? stall_n : 0);
      t = 0;
      while (bus.rsp_valid !== 1'b1 && t < 20) begin
         @(negedge clk); t++;
      end
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_rdata", bus.rsp_rdata, rd);
      chk("rsp_err", bus.rsp_err, 1'b0);
      last_rsp_cyc = cyc;
      @(negedge clk);
      chk("rsp_one_cycle", bus.rsp_valid, 1'b0);
      chk("rdata_held", bus.rsp_rdata, rd);
   endtask

   initial begin
      req_t a;
      req_t b;
      int seen;
      bus.req_valid = 0; bus.req_write = 0; bus.req_high = 0;
      bus.req_addr = 0; bus.req_wdata = 0; bus.tx_ready = 0;
      bus.rx_valid = 0; bus.rx_data = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
      chk("rst_rsp_err", bus.rsp_err, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);

      // directed write and read
      txn('{1'b1, 1'b1, 6'h05, 8'hA5}, 32'h0, -1, 0, 0, '0, 0);
      txn('{1'b0, 1'b0, 6'h12, 8'h00}, 32'h443C2211, -1, 0, 0, '0, 0);
      // shifter stalls 7 cycles on B1 of a write
      txn('{1'b1, 1'b0, 6'h2A, 8'h5E}, 32'h0, 1, 7, 0, '0, 0);

      // reset while waiting for rx of read byte 1
      drive_req('{1'b0, 1'b1, 6'h33, 8'h00});
      accept_req(0, '0, 0);
      send_byte(0, {2'b01, 6'h33}, 8'h99, 0);
      wait_tx("tx_valid_rst_b1");
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_tx_valid", bus.tx_valid, 1'b0);
      chk("midrst_req_ready", bus.req_ready, 1'b1);
      chk("midrst_busy", bus.busy, 1'b0);
      seen = 0;
      bus.rx_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (bus.rsp_valid === 1'b1) seen++;
         @(negedge clk);
         bus.rx_valid = 1'b0;
      end
      chk("midrst_no_rsp", seen, 0);
      txn('{1'b1, 1'b0, 6'h01, 8'h7F}, 32'h0, -1, 0, 0, '0, 0);

      // back-to-back with req_valid held high
      a = '{1'b1, 1'b1, 6'h3F, 8'hC3};
      b = '{1'b0, 1'b1, 6'h00, 8'h00};
      drive_req(a);
      txn(a, 32'h0, -1, 0, 1, b, 0);
      txn(b, 32'hDEADBEEF, -1, 0, 0, '0, 1);

      // randomized accesses
      for (int r = 0; r < 10; r++) begin
         a = req_t'($urandom);
         txn(a, $urandom, (r % 3 == 0) ? int'($urandom_range(0, 3)) : -1,
             int'($urandom_range(1, 4)), 0, '0, 0);
      end

      // no response forever without timeout support
      drive_req('{1'b0, 1'b0, 6'h07, 8'h00});
      accept_req(0, '0, 0);
      send_byte(0, {2'b00, 6'h07}, 8'h00, 0);
      seen = 0;
      for (int k = 0; k < 1000; k++) begin
         if (bus.rsp_valid === 1'b1) seen++;
         @(negedge clk);
      end
      chk("no_timeout_rsp", seen, 0);
      chk("no_timeout_busy", bus.busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("final_idle", bus.req_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
